ram_addr_encoder_8x3: RTL

- Reverse direction of the RAM row decoder: collects row-access request lines and encodes them into a 3-bit row address.
- Requests are buffered in a sticky pending register and issued one at a time over a valid/ready handshake toward the RAM address/control path.
- Sits between the 8 per-row request sources and the decoder input.
- Registered outputs only; no combinational path from req to addr_out.

---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_prio_pick.sv | 31 +++
 rtl/ram_addr_encoder_8x3.sv | 106 ++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared RAM row constants and the encoder state type.
package ram_pkg;

    localparam int RAM_ROWS = 8;
    localparam int RAM_AW   = 3;

    typedef enum logic {
        ENC_IDLE,
        ENC_HOLD
    } encoder_state_t;

endpackage

// File: rtl/ram_prio_pick.sv
// Combinational find-first-set over N bits, starting at i_offset and wrapping to index 0.
// Zero latency; no handshake.
module ram_prio_pick
    import ram_pkg::*;
#(
    parameter int N  = RAM_ROWS,
    parameter int AW = RAM_AW
) (
    input  logic [N-1:0]  vec,
    input  logic [AW-1:0] offset,
    output logic [AW-1:0] idx,
    output logic          found
);

    logic [AW-1:0] w_cand;

    // Walk from the far end down so the nearest candidate to the offset is written last.
    always_comb begin
        idx    = '0;
        w_cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = offset + AW'(i);
            if (vec[w_cand]) begin
                idx = w_cand;
            end
        end
    end

    assign found = |vec;

endmodule

// File: rtl/ram_addr_encoder_8x3.sv
// Sticky row-request collector issuing one encoded row address per valid/ready handshake.
// Request-to-valid latency 2 edges; addr_out is held until accepted. Define RR_PRIORITY_EN for round-robin.
module ram_addr_encoder_8x3
    import ram_pkg::*;
#(
    parameter int N  = RAM_ROWS,
    parameter int AW = RAM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    input  logic          ready_in,
    output logic [AW-1:0] addr_out,
    output logic          valid_out,
    output logic [N-1:0]  pending,
    output logic          overflow,
    output logic          idle
);

    encoder_state_t r_state;
    logic [N-1:0]   r_pending;
    logic [AW-1:0]  r_addr;
    logic           r_valid;
    logic           r_overflow;

    logic [AW-1:0]  w_offset;
    logic [AW-1:0]  w_sel;
    logic           w_found;
    logic           w_load;
    logic [N-1:0]   w_clr;
    logic [N-1:0]   w_req_en;

`ifdef RR_PRIORITY_EN
    logic [AW-1:0]  r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_load) begin
            r_ptr <= w_sel + 1'b1;
        end
    end

    assign w_offset = r_ptr;
`else
    assign w_offset = '0;
`endif

    ram_prio_pick #(
        .N  (N),
        .AW (AW)
    ) u_pick (
        .vec    (r_pending),
        .offset (w_offset),
        .idx    (w_sel),
        .found  (w_found)
    );

    // The held address was cleared at its own load, so r_pending is already the remainder.
    assign w_load   = en & w_found & ((r_state == ENC_IDLE) | ready_in);
    assign w_clr    = w_load ? (N'(1) << w_sel) : '0;
    assign w_req_en = req & {N{en}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ENC_IDLE;
            r_pending  <= '0;
            r_addr     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= (r_pending & ~w_clr) | w_req_en;
            r_overflow <= |(w_req_en & r_pending & ~w_clr);
            case (r_state)
                ENC_IDLE: begin
                    if (w_load) begin
                        r_addr  <= w_sel;
                        r_valid <= 1'b1;
                        r_state <= ENC_HOLD;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                ENC_HOLD: begin
                    if (ready_in) begin
                        if (w_load) begin
                            r_addr <= w_sel;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= ENC_IDLE;
                        end
                    end
                end
                default: r_state <= ENC_IDLE;
            endcase
        end
    end

    assign addr_out  = r_addr;
    assign valid_out = r_valid;
    assign pending   = r_pending;
    assign overflow  = r_overflow;
    assign idle      = (r_pending == '0) & ~r_valid;

endmodule
